// File: rtl/raster_scheduler_pkg.sv
// Shared types for the raster frame sequencer: scheduler states and triangle list entries.
// Triangle3D / Color mirror the colorloop vertex and colour formats.
// Screen geometry macros (WIDTH, HEIGHT, CHUNK_SIZE) fall back to defaults when not set by the build.
`ifndef WIDTH
`define WIDTH 64
`endif
`ifndef HEIGHT
`define HEIGHT 32
`endif
`ifndef CHUNK_SIZE
`define CHUNK_SIZE 16
`endif

package raster_scheduler_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D v0;
    Vertex3D v1;
    Vertex3D v2;
  } Triangle3D;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } Color;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    DISPATCH,
    WAIT_DONE,
    RELEASE,
    FRAME_DONE
  } sched_state_t;

  typedef struct packed {
    Triangle3D ver;
    Color      rgb;
  } tri_entry_t;

endpackage

// File: rtl/tri_list_buf.sv
// Triangle list storage: DEPTH x tri_entry_t register array, one write port, one registered read port.
// Latency: read data appears the cycle after rd_en_i; writes visible to reads issued the next cycle.
// Backpressure: none; the scheduler never writes and reads the same cycle.
module tri_list_buf
  import raster_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  tri_entry_t               wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output tri_entry_t               rd_data_o
);

  tri_entry_t mem_q [DEPTH];
  tri_entry_t rd_data_q;

  // Storage array; contents are only meaningful below the scheduler's count, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register holds the last fetched entry until the next explicit read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/raster_scheduler.sv
// Frame sequencer: buffers a triangle list, clears z via new_frame, then replays the list once per chunk into colorloop.
// Latency: new_frame the cycle after the last accept; first color_en CLEAR_CYCLES later; 3 cycles + colorloop time per triangle.
// Backpressure: tri_ready low outside LOAD or when full; WAIT_DONE stalls on cl_done (bounded by TIMEOUT under RASTER_SCHED_TIMEOUT_EN).
module raster_scheduler
  import raster_scheduler_pkg::*;
#(
  parameter int TRI_DEPTH    = 8,
  parameter int CLEAR_CYCLES = `WIDTH * `HEIGHT + 2,
  parameter int NUM_CHUNKS   = `HEIGHT / `CHUNK_SIZE
`ifdef RASTER_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT      = 4096
`endif
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          tri_valid,
  input  Triangle3D                     tri_in,
  input  Color                          rgb_in,
  input  logic                          tri_last,
  output logic                          tri_ready,
  output logic                          cl_new_frame,
  output logic                          cl_color_en,
  output logic [15:0]                   cl_height,
  output logic [$clog2(NUM_CHUNKS)-1:0] cl_chunk,
  output Triangle3D                     cl_ver,
  output Color                          cl_rgb,
  input  logic                          cl_done,
  output logic                          cl_all_done,
  output logic                          frame_done,
  output logic                          busy
`ifdef RASTER_SCHED_TIMEOUT_EN
  ,
  output logic                          sched_err
`endif
);

  localparam int PW = $clog2(TRI_DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(NUM_CHUNKS);
  localparam int LW = $clog2(CLEAR_CYCLES + 1);

  sched_state_t  state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [KW-1:0] chunk_q, chunk_d;
  logic [LW-1:0] clr_q, clr_d;

  logic          buf_wr_en;
  logic          buf_rd_en;
  tri_entry_t    buf_wr_dat;
  tri_entry_t    buf_rd_dat;

`ifdef RASTER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
`endif

  assign buf_wr_dat.ver = tri_in;
  assign buf_wr_dat.rgb = rgb_in;

  tri_list_buf #(
    .DEPTH(TRI_DEPTH)
  ) u_buf (
    .clk_i    (clk),
    .rst_i    (n_rst),
    .wr_en_i  (buf_wr_en),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(buf_wr_dat),
    .rd_en_i  (buf_rd_en),
    .rd_addr_i(rd_ptr_d),
    .rd_data_o(buf_rd_dat)
  );

  // State and bookkeeping registers; n_rst is active-high despite its name.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      chunk_q  <= '0;
      clr_q    <= '0;
`ifdef RASTER_SCHED_TIMEOUT_EN
      to_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      chunk_q  <= chunk_d;
      clr_q    <= clr_d;
`ifdef RASTER_SCHED_TIMEOUT_EN
      to_q     <= to_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and pulse decode. The buffer read is issued on the transition into DISPATCH
  // so the entry is already registered on cl_ver/cl_rgb when color_en fires.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    chunk_d      = chunk_q;
    clr_d        = clr_q;
    buf_wr_en    = 1'b0;
    buf_rd_en    = 1'b0;
    tri_ready    = 1'b0;
    cl_new_frame = 1'b0;
    cl_color_en  = 1'b0;
    cl_all_done  = 1'b0;
    frame_done   = 1'b0;
`ifdef RASTER_SCHED_TIMEOUT_EN
    to_d         = to_q;
    err_d        = err_q;
`endif
    case (state_q)
      LOAD: begin
        tri_ready = (count_q < CW'(TRI_DEPTH));
        if (tri_valid && tri_ready) begin
          buf_wr_en = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          count_d   = count_q + 1'b1;
`ifdef RASTER_SCHED_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          // A full buffer closes the frame even without tri_last.
          if (tri_last || (count_q == CW'(TRI_DEPTH - 1))) begin
            state_d = CLEAR;
            clr_d   = LW'(CLEAR_CYCLES - 1);
          end
        end
      end
      CLEAR: begin
        cl_new_frame = (clr_q == LW'(CLEAR_CYCLES - 1));
        if (clr_q == '0) begin
          state_d   = DISPATCH;
          rd_ptr_d  = '0;
          chunk_d   = '0;
          buf_rd_en = 1'b1;
        end else begin
          clr_d = clr_q - 1'b1;
        end
      end
      DISPATCH: begin
        cl_color_en = 1'b1;
        state_d     = WAIT_DONE;
`ifdef RASTER_SCHED_TIMEOUT_EN
        to_d        = '0;
`endif
      end
      WAIT_DONE: begin
        if (cl_done) begin
          state_d = RELEASE;
        end
`ifdef RASTER_SCHED_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT - 1)) begin
          // Give up on this triangle; colorloop is released and the list continues.
          state_d = RELEASE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        cl_all_done = 1'b1;
        if ({1'b0, rd_ptr_q} != (count_q - 1'b1)) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          state_d   = DISPATCH;
          buf_rd_en = 1'b1;
        end else if (chunk_q != KW'(NUM_CHUNKS - 1)) begin
          rd_ptr_d  = '0;
          chunk_d   = chunk_q + 1'b1;
          state_d   = DISPATCH;
          buf_rd_en = 1'b1;
        end else begin
          state_d = FRAME_DONE;
        end
      end
      FRAME_DONE: begin
        frame_done = 1'b1;
        count_d    = '0;
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        chunk_d    = '0;
        state_d    = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign busy      = (state_q != LOAD);
  assign cl_height = '0;
  assign cl_chunk  = chunk_q;
  assign cl_ver    = buf_rd_dat.ver;
  assign cl_rgb    = buf_rd_dat.rgb;
`ifdef RASTER_SCHED_TIMEOUT_EN
  assign sched_err = err_q;
`endif

endmodule
